// File: rtl/dac_sample_scheduler.sv
// Paces samples from two requesters into a DAC controller at a fixed slot rate.
// Optional macro DAC_SCHED_MIX_EN averages both requesters when both are valid.
module dac_sample_scheduler #(
    parameter int SAMPLE_DIVIDER = 2268,
    parameter int START_TIMEOUT  = 255
) (
    input  logic        clock_50Mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic        reqA_valid,
    input  logic [11:0] reqA_sample,
    input  logic        reqB_valid,
    input  logic [11:0] reqB_sample,
    output logic        reqA_ack,
    output logic        reqB_ack,
    output logic [11:0] dac_inputSample,
    output logic        dac_sendSample_n,
    input  logic        dac_isBusy,
    input  logic        dac_transmitComplete,
    output logic [7:0]  underrunCount,
    output logic [7:0]  overrunCount,
    output logic        dac_fault,
    output logic [1:0]  dbg_state_o
);

    localparam int DIV_W = (SAMPLE_DIVIDER > 1) ? $clog2(SAMPLE_DIVIDER) : 1;
    localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [11:0]        sample_q, sample_d;
    logic               rr_q, rr_d;
    logic               fault_q, fault_d;
    logic [7:0]         under_q, under_d;
    logic [7:0]         over_q, over_d;
    logic               busy_m_q, busy_s_q;
    logic               tc_m_q, tc_s_q, tc_p_q;
    logic               tick;
    logic               tc_rise;

`ifdef DAC_SCHED_MIX_EN
    logic [12:0]        mix_sum;
    assign mix_sum = {1'b0, reqA_sample} + {1'b0, reqB_sample};
`endif

    assign tick    = enable && (div_q == DIV_W'(SAMPLE_DIVIDER - 1));
    assign tc_rise = tc_s_q && !tc_p_q;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        rr_d     = rr_q;
        fault_d  = fault_q;
        under_d  = under_q;
        over_d   = over_q;
        reqA_ack = 1'b0;
        reqB_ack = 1'b0;

        if (!enable)
            div_d = '0;
        else if (tick)
            div_d = '0;
        else
            div_d = div_q + DIV_W'(1);

        // A slot can only be taken from IDLE; any other state drops it.
        if (tick && (state_q != IDLE) && (over_q != 8'hFF))
            over_d = over_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (tick)
                    state_d = LOAD;
            end
            LOAD: begin
                state_d = START;
                tmo_d   = '0;
                if (reqA_valid && reqB_valid) begin
`ifdef DAC_SCHED_MIX_EN
                    reqA_ack = 1'b1;
                    reqB_ack = 1'b1;
                    sample_d = mix_sum[12:1];
`else
                    if (!rr_q) begin
                        reqA_ack = 1'b1;
                        sample_d = reqA_sample;
                    end else begin
                        reqB_ack = 1'b1;
                        sample_d = reqB_sample;
                    end
                    rr_d = !rr_q;
`endif
                end else if (reqA_valid) begin
                    reqA_ack = 1'b1;
                    sample_d = reqA_sample;
                end else if (reqB_valid) begin
                    reqB_ack = 1'b1;
                    sample_d = reqB_sample;
                end else if (under_q != 8'hFF) begin
                    // Underrun: sample_q is left alone so the last value is resent.
                    under_d = under_q + 8'd1;
                end
            end
            START: begin
                if (busy_s_q) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tc_rise || !busy_s_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tmo_q    <= '0;
            sample_q <= 12'h800;
            rr_q     <= 1'b0;
            fault_q  <= 1'b0;
            under_q  <= 8'd0;
            over_q   <= 8'd0;
            busy_m_q <= 1'b0;
            busy_s_q <= 1'b0;
            tc_m_q   <= 1'b0;
            tc_s_q   <= 1'b0;
            tc_p_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            rr_q     <= rr_d;
            fault_q  <= fault_d;
            under_q  <= under_d;
            over_q   <= over_d;
            busy_m_q <= dac_isBusy;
            busy_s_q <= busy_m_q;
            tc_m_q   <= dac_transmitComplete;
            tc_s_q   <= tc_m_q;
            tc_p_q   <= tc_s_q;
        end
    end

    // Send request decoded from registered state so reset releases it on the next edge.
    assign dac_sendSample_n = (state_q != START);
    assign dac_inputSample  = sample_q;
    assign underrunCount    = under_q;
    assign overrunCount     = over_q;
    assign dac_fault        = fault_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: slot vector table plus latency, timeout,
// overrun, reset and saturation sequences against a simple DAC controller model.
module tb_dac_sample_scheduler;

    localparam int DIV = 50;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        a_valid, b_valid;
    logic [11:0] a_sample, b_sample;
    logic        a_ack, b_ack;
    logic [11:0] dac_sample;
    logic        dac_send_n;
    logic        dac_busy, dac_tc;
    logic [7:0]  under_cnt, over_cnt;
    logic        fault;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    int  busy_dly   = 3;
    int  done_dly   = 10;
    logic never_busy = 1'b0;
    logic model_active;

    dac_sample_scheduler #(
        .SAMPLE_DIVIDER(DIV),
        .START_TIMEOUT (255)
    ) dut (
        .clock_50Mhz         (clk),
        .reset               (reset),
        .enable              (enable),
        .reqA_valid          (a_valid),
        .reqA_sample         (a_sample),
        .reqB_valid          (b_valid),
        .reqB_sample         (b_sample),
        .reqA_ack            (a_ack),
        .reqB_ack            (b_ack),
        .dac_inputSample     (dac_sample),
        .dac_sendSample_n    (dac_send_n),
        .dac_isBusy          (dac_busy),
        .dac_transmitComplete(dac_tc),
        .underrunCount       (under_cnt),
        .overrunCount        (over_cnt),
        .dac_fault           (fault),
        .dbg_state_o         (dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DAC controller model: busy after busy_dly cycles, complete after done_dly more.
    initial begin
        dac_busy = 1'b0;
        dac_tc = 1'b0;
        model_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!dac_send_n && !never_busy) begin
                model_active = 1'b1;
                repeat (busy_dly) @(negedge clk);
                dac_busy = 1'b1;
                repeat (done_dly) @(negedge clk);
                dac_busy = 1'b0;
                dac_tc = 1'b1;
                @(negedge clk);
                dac_tc = 1'b0;
                model_active = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int bound, input string name);
        int n = 0;
        while (dbg_state !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (dbg_state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual_state=%0d expected_state=%0d", name, dbg_state, s);
        end
    endtask

    task automatic wait_model_idle();
        int n = 0;
        while (model_active && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (model_active) begin
            checks++;
            errors++;
            $display("FAIL model_idle timeout actual=1 expected=0");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_sample = 12'h000;
        b_sample = 12'h000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard table
    typedef struct {
        logic        av;
        logic [11:0] as;
        logic        bv;
        logic [11:0] bs;
        logic        e_ack_a;
        logic        e_ack_b;
        logic [11:0] e_sample;
        logic [7:0]  e_under;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc;
        int extra_ack;
        int extra_send;
        int low_cnt;
        logic prev_send_n;

        reset = 1'b1;
        enable = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_sample = 12'h000;
        b_sample = 12'h000;

        vecs[0] = '{1'b1, 12'hABC, 1'b0, 12'h000, 1'b1, 1'b0, 12'hABC, 8'd0};
`ifdef DAC_SCHED_MIX_EN
        vecs[1] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b1, 12'h180, 8'd0};
        vecs[2] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b1, 12'h180, 8'd0};
        vecs[3] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b1, 12'h180, 8'd0};
        vecs[4] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b1, 12'h180, 8'd0};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h180, 8'd1};
`else
        vecs[1] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b0, 12'h100, 8'd0};
        vecs[2] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0, 1'b1, 12'h200, 8'd0};
        vecs[3] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b1, 1'b0, 12'h100, 8'd0};
        vecs[4] = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0, 1'b1, 12'h200, 8'd0};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h200, 8'd1};
`endif
        vecs[6] = '{1'b0, 12'h000, 1'b1, 12'h321, 1'b0, 1'b1, 12'h321, 8'd1};
        vecs[7] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h321, 8'd2};
`ifdef DAC_SCHED_MIX_EN
        vecs[8] = '{1'b1, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b1, 12'hFFF, 8'd2};
        vecs[9] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b1, 1'b1, 12'h001, 8'd2};
`else
        vecs[8] = '{1'b1, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 8'd2};
        vecs[9] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b1, 12'h002, 8'd2};
`endif

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_send_n", 32'(dac_send_n), 32'd1);
        check("rst_sample", 32'(dac_sample), 32'h800);
        check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_under", 32'(under_cnt), 32'd0);
        check("rst_over", 32'(over_cnt), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        // Single A transfer, latency, and enable dropped mid-transfer
        busy_dly = 40;
        done_dly = 700;
        do_reset();
        a_valid = 1'b1;
        a_sample = 12'hABC;
        enable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!a_ack && cyc < 200);
        check("lat_tick_to_ack", 32'(cyc), 32'(DIV));
        check("lat_ack_b", 32'(b_ack), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        check("lat_send_low", 32'(dac_send_n), 32'd0);
        check("lat_sample", 32'(dac_sample), 32'hABC);
        extra_ack = 0;
        extra_send = 0;
        prev_send_n = dac_send_n;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) extra_ack++;
            if (prev_send_n && !dac_send_n) extra_send++;
            prev_send_n = dac_send_n;
        end
        check("single_extra_acks", 32'(extra_ack), 32'd0);
        check("single_extra_sends", 32'(extra_send), 32'd0);
        check("single_idle", 32'(dbg_state), 32'd0);
        check("single_under", 32'(under_cnt), 32'd0);
        check("single_over", 32'(over_cnt), 32'd0);
        check("single_fault", 32'(fault), 32'd0);
        wait_model_idle();

        // Table of slots with a fast DAC
        busy_dly = 3;
        done_dly = 10;
        do_reset();
        enable = 1'b1;
        for (int v = 0; v < 10; v++) begin
            a_valid = vecs[v].av;
            a_sample = vecs[v].as;
            b_valid = vecs[v].bv;
            b_sample = vecs[v].bs;
            wait_state(2'd1, 200, $sformatf("vec%0d_load", v));
            check($sformatf("vec%0d_ack_a", v), 32'(a_ack), 32'(vecs[v].e_ack_a));
            check($sformatf("vec%0d_ack_b", v), 32'(b_ack), 32'(vecs[v].e_ack_b));
            @(negedge clk);
            check($sformatf("vec%0d_sample", v), 32'(dac_sample), 32'(vecs[v].e_sample));
            check($sformatf("vec%0d_under", v), 32'(under_cnt), 32'(vecs[v].e_under));
            wait_state(2'd0, 300, $sformatf("vec%0d_idle", v));
        end
        check("table_over", 32'(over_cnt), 32'd0);
        enable = 1'b0;
        wait_model_idle();

        // Slow completion: two dropped ticks, then reset in WAIT_DONE
        busy_dly = 3;
        done_dly = 120;
        do_reset();
        a_valid = 1'b1;
        a_sample = 12'h5A5;
        enable = 1'b1;
        wait_state(2'd1, 200, "ovr_load1");
        @(negedge clk);
        wait_state(2'd0, 400, "ovr_idle1");
        check("ovr_count", 32'(over_cnt), 32'd2);
        wait_state(2'd1, 200, "ovr_load2");
        wait_state(2'd3, 100, "ovr_wait2");
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_send_n", 32'(dac_send_n), 32'd1);
        check("midrst_sample", 32'(dac_sample), 32'h800);
        check("midrst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("midrst_under", 32'(under_cnt), 32'd0);
        check("midrst_over", 32'(over_cnt), 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        wait_model_idle();

        // DAC never goes busy: start timeout
        never_busy = 1'b1;
        do_reset();
        a_valid = 1'b1;
        a_sample = 12'h123;
        enable = 1'b1;
        cyc = 0;
        while (dac_send_n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        low_cnt = 0;
        while (!dac_send_n && low_cnt < 1000) begin
            @(negedge clk);
            low_cnt++;
        end
        enable = 1'b0;
        check("tmo_low_cycles", 32'(low_cnt), 32'd255);
        check("tmo_fault", 32'(fault), 32'd1);
        check("tmo_idle", 32'(dbg_state), 32'd0);
        check("tmo_over", 32'(over_cnt), 32'd5);
        repeat (5) @(negedge clk);
        never_busy = 1'b0;

        // Underrun saturation: 300 empty slots
        busy_dly = 3;
        done_dly = 10;
        do_reset();
        check("fault_cleared", 32'(fault), 32'd0);
        enable = 1'b1;
        repeat (300 * DIV + 100) @(negedge clk);
        check("under_sat", 32'(under_cnt), 32'd255);
        check("under_sat_sample", 32'(dac_sample), 32'h800);
        check("under_sat_over", 32'(over_cnt), 32'd0);
        enable = 1'b0;
        repeat (100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
